// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: in-order imem requests, response buffer, decode handshake
// Optional FETCH_PERF_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif

module fetch_unit #(
  parameter logic [`DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                     FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic                          imem_req_valid,
  input  logic                          imem_req_ready,
  output logic [`DATA_WIDTH-1:0]        imem_addr,
  input  logic                          imem_rsp_valid,
  input  logic [`INSTRUCTION_WIDTH-1:0] imem_rsp_data,
  input  logic                          redirect_valid,
  input  logic [`DATA_WIDTH-1:0]        redirect_pc,
  output logic                          dec_valid,
  input  logic                          dec_ready,
  output logic [`INSTRUCTION_WIDTH-1:0] dec_instruction,
  output logic [`DATA_WIDTH-1:0]        dec_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]                   perf_fetch_cnt,
  output logic [31:0]                   perf_stall_cnt
`endif
);

  localparam int             CW      = $clog2(FIFO_DEPTH) + 1;
  localparam int             DW      = `DATA_WIDTH;
  localparam int             IW      = `INSTRUCTION_WIDTH;
  localparam logic [CW:0]    DEPTH_W = (CW+1)'(FIFO_DEPTH);

  logic [DW-1:0] fetch_pc;
  logic [DW-1:0] rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_count;

  // Shift-register buffer: entry 0 is always the head, so decode outputs come straight from flops.
  logic [IW-1:0] buf_instr      [FIFO_DEPTH];
  logic [DW-1:0] buf_pc         [FIFO_DEPTH];
  logic [IW-1:0] buf_instr_next [FIFO_DEPTH];
  logic [DW-1:0] buf_pc_next    [FIFO_DEPTH];

  logic          req_fire;
  logic          pop;
  logic          push;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] count_next;
  logic [CW-1:0] wr_idx;
  logic [DW-1:0] redirect_aligned;

  assign imem_req_valid   = reset && !redirect_valid &&
                            (({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_W);
  assign imem_addr        = fetch_pc;
  assign req_fire         = imem_req_valid && imem_req_ready;
  assign dec_valid        = (fifo_count != '0);
  assign pop              = dec_valid && dec_ready;
  assign push             = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
  assign dec_instruction  = buf_instr[0];
  assign dec_pc           = buf_pc[0];
  assign redirect_aligned = redirect_pc & ~DW'(3);
  assign outstanding_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
  assign wr_idx           = fifo_count - CW'(pop);

  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      buf_instr_next[i] = buf_instr[i];
      buf_pc_next[i]    = buf_pc[i];
    end
    if (pop) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
        buf_instr_next[i] = buf_instr[i+1];
        buf_pc_next[i]    = buf_pc[i+1];
      end
    end
    if (push) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (CW'(i) == wr_idx) begin
          buf_instr_next[i] = imem_rsp_data;
          buf_pc_next[i]    = rsp_pc;
        end
      end
    end
    count_next = fifo_count + CW'(push) - CW'(pop);
    if (redirect_valid) begin
      count_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      fifo_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        buf_instr[i] <= '0;
        buf_pc[i]    <= '0;
      end
    end else begin
      outstanding <= outstanding_next;
      fifo_count  <= count_next;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        buf_instr[i] <= buf_instr_next[i];
        buf_pc[i]    <= buf_pc_next[i];
      end
      // Every request still in flight after this cycle belongs to the abandoned path.
      if (redirect_valid) begin
        fetch_pc <= redirect_aligned;
        rsp_pc   <= redirect_aligned;
        drop_cnt <= outstanding_next;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + DW'(4);
        end
        if (imem_rsp_valid) begin
          if (drop_cnt != '0) begin
            drop_cnt <= drop_cnt - CW'(1);
          end else begin
            rsp_pc <= rsp_pc + DW'(4);
          end
        end
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (pop) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (dec_valid && !dec_ready) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a queue-based fetch model
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif

module tb_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instruction;
  logic [31:0] dec_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_instruction(dec_instruction), .dec_pc(dec_pc)
`ifdef FETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic live; } inf_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  typedef struct { logic [31:0] data; int due; } mem_t;
  typedef struct { logic [31:0] addr; int cyc; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; int cyc; } pop_t;

  inf_t inflight[$];
  ent_t buf_q[$];
  mem_t mem_q[$];
  req_t req_log[$];
  pop_t pop_log[$];
  int   rsp_log[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cycle_n  = 0;
  int          lat_max  = 0;
  bit          fixed_data = 1'b0;
  bit          model_ok = 1'b0;
  logic        exp_rv;
  logic [31:0] m_fetch_pc;
  logic [31:0] m_fetch_cnt;
  logic [31:0] m_stall_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cycle_n);
    end
  endtask

  function automatic logic [31:0] req_at(int k);
    return (k < req_log.size()) ? req_log[k].addr : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] pop_pc_at(int k);
    return (k < pop_log.size()) ? pop_log[k].pc : 32'hDEAD_BEEF;
  endfunction

  // Reference model: requests carry their own PC; a redirect kills everything still in flight.
  always @(negedge clk) begin
    inf_t e;
    ent_t b;
    mem_t m;
    req_t r;
    pop_t p;
    if (model_ok) begin
      exp_rv = reset && !redirect_valid && ((inflight.size() + buf_q.size()) < DEPTH);
      check("imem_req_valid", imem_req_valid, exp_rv);
      check("imem_addr", imem_addr, m_fetch_pc);
      check("dec_valid", dec_valid, buf_q.size() > 0);
      if (buf_q.size() > 0) begin
        check("dec_instruction", dec_instruction, buf_q[0].instr);
        check("dec_pc", dec_pc, buf_q[0].pc);
      end
`ifdef FETCH_PERF_EN
      check("perf_fetch_cnt", perf_fetch_cnt, m_fetch_cnt);
      check("perf_stall_cnt", perf_stall_cnt, m_stall_cnt);
`endif
    end
    if (reset === 1'b0) begin
      m_fetch_pc  = RESET_PC;
      m_fetch_cnt = '0;
      m_stall_cnt = '0;
      inflight.delete();
      buf_q.delete();
      mem_q.delete();
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (dec_valid && dec_ready) begin
        p.pc = dec_pc; p.instr = dec_instruction; p.cyc = cycle_n;
        pop_log.push_back(p);
      end
      if (imem_rsp_valid) rsp_log.push_back(cycle_n);
      if (imem_req_valid && imem_req_ready) begin
        r.addr = imem_addr; r.cyc = cycle_n;
        req_log.push_back(r);
        m.data = fixed_data ? 32'h0000_0013 : $urandom;
        m.due  = cycle_n + 1 + int'($urandom_range(0, lat_max));
        mem_q.push_back(m);
      end
      if (buf_q.size() > 0) begin
        if (dec_ready) begin
          buf_q.delete(0);
          m_fetch_cnt = m_fetch_cnt + 1;
        end else begin
          m_stall_cnt = m_stall_cnt + 1;
        end
      end
      if (imem_rsp_valid && inflight.size() > 0) begin
        e = inflight[0];
        inflight.delete(0);
        if (!redirect_valid && e.live) begin
          check("fifo_no_overflow", buf_q.size() < DEPTH, 1'b1);
          b.instr = imem_rsp_data; b.pc = e.pc;
          buf_q.push_back(b);
        end
      end
      if (exp_rv && imem_req_ready) begin
        e.pc = m_fetch_pc; e.live = 1'b1;
        inflight.push_back(e);
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
      if (redirect_valid) begin
        buf_q.delete();
        for (int i = 0; i < inflight.size(); i++) begin
          e = inflight[i]; e.live = 1'b0; inflight[i] = e;
        end
        m_fetch_pc = {redirect_pc[31:2], 2'b00};
      end
    end
  end

  task automatic next_cycle(input logic rsp_en);
    @(posedge clk);
    #1;
    cycle_n++;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (rsp_en && mem_q.size() > 0 && mem_q[0].due <= cycle_n) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_q[0].data;
      mem_q.delete(0);
    end
  endtask

  task automatic cyc(input logic rst_n, input logic rq_rdy, input logic d_rdy,
                     input logic redir, input logic [31:0] rpc, input logic rsp_en);
    next_cycle(rsp_en);
    reset          = rst_n;
    imem_req_ready = rq_rdy;
    dec_ready      = d_rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    req_log.delete();
    pop_log.delete();
    rsp_log.delete();
  endtask

  initial begin
    int rel;
    int stalls;
    int pops;
    reset = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;

    // Zero-wait sequential fetch with constant instruction word.
    lat_max = 0; fixed_data = 1'b1;
    do_reset();
    check("reset_dec_valid", dec_valid, 1'b0);
    check("reset_dec_pc", dec_pc, 32'h0);
    check("reset_dec_instruction", dec_instruction, 32'h0);
    check("reset_req_valid", imem_req_valid, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    rel = cycle_n;
    repeat (9) cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    check("seq_req0", req_at(0), 32'h0);
    check("seq_req1", req_at(1), 32'h4);
    check("seq_req2", req_at(2), 32'h8);
    check("seq_first_req_cycle", (req_log.size() > 0) ? req_log[0].cyc : -1, rel);
    check("seq_pop0", pop_pc_at(0), 32'h0);
    check("seq_pop1", pop_pc_at(1), 32'h4);
    check("seq_pop2", pop_pc_at(2), 32'h8);
    check("seq_instr", (pop_log.size() > 0) ? pop_log[0].instr : 32'hDEAD_BEEF, 32'h13);
    for (int k = 0; k < 3; k++)
      check("seq_latency", (k < pop_log.size()) ? pop_log[k].cyc : -1,
            (k < rsp_log.size()) ? rsp_log[k] + 1 : -2);

    // Decode backpressure.
    fixed_data = 1'b0;
    do_reset();
    repeat (6) cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    check("bp_req_count", req_log.size(), 2);
    check("bp_req_valid_low", imem_req_valid, 1'b0);
    check("bp_dec_valid", dec_valid, 1'b1);
    check("bp_dec_pc", dec_pc, 32'h0);
    repeat (4) cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    check("bp_resume_addr", req_at(2), 32'h8);

    // Redirect with two responses still outstanding.
    do_reset();
    repeat (4) cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    check("rd_outstanding", req_log.size(), 2);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 1'b0);
    check("rd_no_req_in_redirect", imem_req_valid, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    check("rd_next_addr", imem_addr, 32'h100);
    repeat (8) cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    check("rd_req_after", req_at(2), 32'h100);
    check("rd_first_pop", pop_pc_at(0), 32'h100);

    // Misaligned redirect coinciding with a response.
    do_reset();
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h203, 1'b1);
    check("mis_no_req", imem_req_valid, 1'b0);
    repeat (6) cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    check("mis_req_addr", req_at(1), 32'h200);
    check("mis_first_pop", pop_pc_at(0), 32'h200);

    // Reset while the buffer is full.
    do_reset();
    repeat (6) cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    check("mr_full_valid", dec_valid, 1'b1);
    req_log.delete();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    check("mr_req_valid_in_reset", imem_req_valid, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    check("mr_dec_valid", dec_valid, 1'b0);
    check("mr_addr", imem_addr, RESET_PC);
    repeat (3) cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    check("mr_first_req", req_at(0), RESET_PC);

    // Randomized traffic; the model checks every cycle.
    lat_max = 2;
    for (int k = 0; k < 3000; k++)
      cyc($urandom_range(0, 199) != 0, ($urandom % 4) != 0, ($urandom % 3) != 0,
          $urandom_range(0, 24) == 0, $urandom, ($urandom % 4) != 0);

`ifdef FETCH_PERF_EN
    lat_max = 0;
    do_reset();
    stalls = 0; pops = 0;
    for (int k = 0; k < 60 && !(stalls == 4 && pops == 3); k++) begin
      next_cycle(1'b1);
      reset = 1'b1; imem_req_ready = 1'b1; redirect_valid = 1'b0;
      if (dec_valid) begin
        if (stalls < 4) begin dec_ready = 1'b0; stalls++; end
        else begin dec_ready = 1'b1; pops++; end
      end else begin
        dec_ready = 1'b0;
      end
    end
    next_cycle(1'b0);
    check("perf_fetch_literal", perf_fetch_cnt, 32'd3);
    check("perf_stall_literal", perf_stall_cnt, 32'd4);
    dec_ready = 1'b1;
`endif
    stalls = 0; pops = 0;

    repeat (3) cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage, directly upstream of DECODE.
- Generates sequential PCs and issues in-order requests to instruction memory.
- Buffers returned words with their PCs in a small FIFO.
- Presents {instruction, pc} to DECODE over a valid/ready handshake; branch/jump redirects flush in-flight work.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of 2, >= 2.
- Data and instruction widths come from the shared constants header as `DATA_WIDTH` and `INSTRUCTION_WIDTH` (both 32).

Ports:
- clk  input  1  system clock, all state on posedge.
- reset  input  1  synchronous, active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_addr  output  DATA_WIDTH  request address, word aligned.
- imem_rsp_valid  input  1  response data valid; in-order, always accepted.
- imem_rsp_data  input  INSTRUCTION_WIDTH  returned instruction word.
- redirect_valid  input  1  branch/jump taken, one-cycle pulse.
- redirect_pc  input  DATA_WIDTH  redirect target.
- dec_valid  output  1  instruction available to DECODE.
- dec_ready  input  1  DECODE consumes.
- dec_instruction  output  INSTRUCTION_WIDTH  FIFO head word.
- dec_pc  output  DATA_WIDTH  PC of FIFO head.

Behaviour:
- Reset (reset==0 at posedge):
  - fetch_pc=RESET_PC, rsp_pc=RESET_PC.
  - FIFO empty; outstanding=0; drop_cnt=0.
  - imem_req_valid=0, dec_valid=0, dec_instruction=0, dec_pc=0.
  - Reset mid-operation discards all buffered and outstanding state; responses arriving after reset release are not guarded.
- Request issue:
  - imem_req_valid=1 when (outstanding + fifo_count) < FIFO_DEPTH and redirect_valid==0.
  - imem_addr=fetch_pc.
  - On handshake: fetch_pc += 4 (wraps modulo 2^32) and outstanding += 1.
  - imem_req_valid may drop without a handshake.
- Response:
  - Every imem_rsp_valid decrements outstanding.
  - If drop_cnt>0, the word is discarded and drop_cnt decrements.
  - Otherwise push {imem_rsp_data, rsp_pc} and rsp_pc += 4.
  - Overflow is impossible by the issue rule; the bench asserts it never occurs.
- Output:
  - dec_valid = FIFO non-empty; dec_instruction/dec_pc = head, registered.
  - Pop on dec_valid && dec_ready.
  - Latency: response at cycle M -> dec_valid at M+1.
  - First request is issued the cycle after reset release.
  - Push and pop in the same cycle: count unchanged. Pop at full re-enables issue next cycle.
- Redirect (redirect_valid==1):
  - Next edge: fetch_pc=rsp_pc={redirect_pc[31:2],2'b00}, FIFO flushed.
  - drop_cnt = outstanding after this cycle's updates, i.e. including responses still due.
  - A response arriving in the redirect cycle is discarded and does not count toward drop_cnt.
  - No request is issued in the redirect cycle.
  - A pop in the redirect cycle is allowed, but the flushed entries are gone.
  - New request goes out on the following cycle.
  - Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
- Counter widths: outstanding, drop_cnt and fifo_count are $clog2(FIFO_DEPTH)+1 bits.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, two extra output ports are present:
  - perf_fetch_cnt (32): increments on each dec_valid && dec_ready.
  - perf_stall_cnt (32): increments on each cycle with dec_valid && !dec_ready.
  - Both reset to 0, wrap at 2^32, and are not cleared by redirect.
- When undefined, neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Zero-wait sequential fetch: reset release, imem_req_ready=1, one-cycle response with data 0x00000013, dec_ready=1 -> requests to 0x0, 0x4, 0x8; dec_pc 0x0, 0x4, 0x8 in order, each one cycle after its response.
- Backpressure: dec_ready=0 -> exactly 2 requests are accepted, then imem_req_valid=0; dec_valid stays 1 with dec_pc=0x0. Raising dec_ready resumes requests at 0x8.
- Redirect with 2 outstanding: redirect_pc=0x100 -> both late responses are dropped; next imem_addr=0x100; first dec_pc=0x100.
- Misaligned and simultaneous events: redirect_pc=0x203 coincides with a response -> that response is discarded; next imem_addr=0x200.
- Mid-operation reset: FIFO full, reset=0 for one cycle -> dec_valid=0 and imem_req_valid=0; after release the next imem_addr is RESET_PC.
- FETCH_PERF_EN build: 3 pops plus 4 stalled cycles -> perf_fetch_cnt=3, perf_stall_cnt=4.
